// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers strobed bytes, serves edge-triggered pop/status reads on UARTOp.
// RxData updates 1 cycle after a command edge; pushes while full are dropped and flagged sticky Overflow.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DataReadFromLine,
  input  logic [31:0]       ReadData,
  input  logic [1:0]        UARTOp,
  output logic [31:0]       RxData,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow,
  output logic [ADDR_W:0]   Count
);

  localparam int PAD_W = 29 - ADDR_W - 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        op_prev;

  logic pop_cmd;
  logic stat_cmd;
  logic pop_ok;
  logic push_ok;
  logic drop;
  logic unused_hi;

  assign unused_hi = ^ReadData[31:8];

  assign Empty = (Count == '0);
  assign Full  = (Count == (ADDR_W+1)'(DEPTH));

  // Commands act only on the first cycle UARTOp takes a value.
  assign pop_cmd  = (UARTOp == 2'b01) && (op_prev != 2'b01);
  assign stat_cmd = (UARTOp == 2'b11) && (op_prev != 2'b11);

  assign pop_ok  = pop_cmd && !Empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = !reset && DataReadFromLine && (!Full || pop_cmd);
  assign drop    = DataReadFromLine && Full && !pop_cmd;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= ReadData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      RxData   <= '0;
      Overflow <= 1'b0;
      op_prev  <= 2'b00;
    end else begin
      op_prev <= UARTOp;

      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      case ({push_ok, pop_ok})
        2'b10:   Count <= Count + (ADDR_W+1)'(1);
        2'b01:   Count <= Count - (ADDR_W+1)'(1);
        default: Count <= Count;
      endcase

      if (pop_cmd) begin
        RxData <= pop_ok ? {24'h0, mem[rd_ptr]} : 32'hFFFF_FFFF;
      end else if (stat_cmd) begin
        RxData <= {Overflow, Full, Empty, {PAD_W{1'b0}}, Count};
      end

      // A drop in the same cycle as a status read keeps the flag set.
      if (drop) begin
        Overflow <= 1'b1;
      end else if (stat_cmd) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              DataReadFromLine = 1'b0;
  logic [31:0]       ReadData = '0;
  logic [1:0]        UARTOp = 2'b00;
  logic [31:0]       RxData;
  logic              Empty;
  logic              Full;
  logic              Overflow;
  logic [ADDR_W:0]   Count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0;
  logic [1:0]  m_prev = 2'b00;
  logic [31:0] exp_q[$];

  // Monitor's own view of command edges
  logic [1:0]  mon_prev = 2'b00;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .DataReadFromLine(DataReadFromLine),
    .ReadData(ReadData),
    .UARTOp(UARTOp),
    .RxData(RxData),
    .Empty(Empty),
    .Full(Full),
    .Overflow(Overflow),
    .Count(Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any command edge produces a response on RxData one cycle later.
  always @(posedge clk) begin
    logic fire;
    fire = !reset && ((UARTOp == 2'b01 && mon_prev != 2'b01) ||
                      (UARTOp == 2'b11 && mon_prev != 2'b11));
    mon_prev = reset ? 2'b00 : UARTOp;
    if (fire) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rxdata_unexpected: got 0x%08h with no expected response", RxData);
      end else begin
        check("rxdata", RxData, exp_q.pop_front());
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(Count), 32'(mq.size()));
    check({tag, "_empty"}, 32'(Empty), 32'(mq.size() == 0));
    check({tag, "_full"},  32'(Full),  32'(mq.size() == DEPTH));
    check({tag, "_ovf"},   32'(Overflow), 32'(m_ovf));
  endtask

  // One clock: drive at negedge, update the model, verify flags at the next negedge.
  task automatic cyc(input logic p, input logic [7:0] b, input logic [1:0] op);
    logic pop_f, stat_f, drop;
    int   old_size;
    DataReadFromLine = p;
    ReadData = $urandom;
    ReadData[7:0] = b;
    UARTOp = op;

    pop_f  = (op == 2'b01) && (m_prev != 2'b01);
    stat_f = (op == 2'b11) && (m_prev != 2'b11);
    m_prev = op;
    old_size = mq.size();
    drop = 1'b0;

    if (pop_f) begin
      if (old_size > 0) exp_q.push_back({24'h0, mq.pop_front()});
      else              exp_q.push_back(32'hFFFF_FFFF);
    end
    if (stat_f)
      exp_q.push_back({m_ovf, old_size == DEPTH, old_size == 0, 24'h0, 5'(old_size)});
    if (p) begin
      if (old_size < DEPTH || pop_f) mq.push_back(b);
      else drop = 1'b1;
    end
    if (stat_f) m_ovf = 1'b0;
    if (drop)   m_ovf = 1'b1;

    @(negedge clk);
    check_status("flags");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    DataReadFromLine = 1'b1;
    ReadData = $urandom;
    UARTOp = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    DataReadFromLine = 1'b0;
    UARTOp = 2'b00;
    mq.delete();
    m_ovf = 1'b0;
    m_prev = 2'b00;
    check("reset_rxdata", RxData, 32'h0);
    check_status("reset");
  endtask

  task automatic pop_gap();
    cyc(1'b0, 8'h00, 2'b01);
    cyc(1'b0, 8'h00, 2'b00);
  endtask

  task automatic stat_gap();
    cyc(1'b0, 8'h00, 2'b11);
    cyc(1'b0, 8'h00, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    @(negedge clk);
    do_reset();

    // Empty status after reset
    stat_gap();

    // Three bytes in, three out in order, then the empty sentinel
    cyc(1'b1, 8'h41, 2'b00);
    cyc(1'b1, 8'h42, 2'b00);
    cyc(1'b1, 8'h43, 2'b00);
    repeat (4) pop_gap();

    // Held pop executes once
    cyc(1'b1, 8'h5A, 2'b00);
    cyc(1'b1, 8'hA5, 2'b00);
    repeat (5) cyc(1'b0, 8'h00, 2'b01);
    cyc(1'b0, 8'h00, 2'b00);
    pop_gap();

    // Overfill: 17 pushes, status clears Overflow
    for (int i = 0; i <= 16; i++) cyc(1'b1, 8'(i), 2'b00);
    stat_gap();
    stat_gap();

    // Full FIFO, simultaneous push and pop
    cyc(1'b1, 8'hEE, 2'b01);
    cyc(1'b0, 8'h00, 2'b00);
    repeat (DEPTH + 1) pop_gap();

    // Pointer wrap with push/pop pairs
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      cyc(1'b1, b, 2'b00);
      pop_gap();
    end

    // Reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 2'b00);
    do_reset();
    pop_gap();

    // Push into empty FIFO during a pop: stored, not returned
    cyc(1'b1, 8'h77, 2'b01);
    cyc(1'b0, 8'h00, 2'b00);
    pop_gap();

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 2) != 0), 8'($urandom), 2'($urandom_range(0, 3)));
    cyc(1'b0, 8'h00, 2'b00);
    cyc(1'b0, 8'h00, 2'b00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
